// File: rtl/lif_array_if.sv
// Bus bundle for lif_array: time-step strobe, input currents, config write port and
// registered spike/state outputs.
interface lif_array_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic             step;
    logic [N*W-1:0]   current;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [W-1:0]     cfg_wdata;
    logic [N-1:0]     spike;
    logic [N*W-1:0]   state;

    modport master (
        output step, current, cfg_we, cfg_addr, cfg_wdata,
        input  spike, state
    );

    modport slave (
        input  step, current, cfg_we, cfg_addr, cfg_wdata,
        output spike, state
    );
endinterface

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons sharing one threshold/mode/refractory config.
// Optional feature: define LIF_REFRACTORY_EN to add per-neuron refractory counters.
module lif_array #(
    parameter int unsigned N          = 4,
    parameter int unsigned W          = 8,
    parameter int unsigned BETA_SHIFT = 1,
    parameter int unsigned REFRAC_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lif_array_if.slave   bus
);

    localparam logic [W-1:0] THRESH_RST  = {1'b0, {(W-1){1'b1}}};
    localparam logic [1:0]   ADDR_THRESH = 2'd0;
    localparam logic [1:0]   ADDR_REFRAC = 2'd1;
    localparam logic [1:0]   ADDR_MODE   = 2'd2;

    if (BETA_SHIFT >= W || REFRAC_W == 0 || REFRAC_W > W) begin : g_param_err
        $error("lif_array: BETA_SHIFT must be < W and REFRAC_W in 1..W");
    end

    logic [W-1:0]   thresh_q, thresh_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   state_q [N];
    logic [W-1:0]   state_d [N];
    logic [N-1:0]   spike_q, spike_d;

    logic [W-1:0]   cur  [N];
    logic [W-1:0]   leak [N];
    logic [W:0]     sum_w [N];
    logic [W-1:0]   sum  [N];

`ifdef LIF_REFRACTORY_EN
    logic [REFRAC_W-1:0] period_q, period_d;
    logic [REFRAC_W-1:0] cnt_q [N];
    logic [REFRAC_W-1:0] cnt_d [N];
`endif

    // Config writes land on this edge; neuron update below still sees the _q values.
    always_comb begin
        thresh_d = thresh_q;
        mode_d   = mode_q;
`ifdef LIF_REFRACTORY_EN
        period_d = period_q;
`endif
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_THRESH: thresh_d = bus.cfg_wdata;
                ADDR_MODE:   mode_d   = bus.cfg_wdata[0];
`ifdef LIF_REFRACTORY_EN
                ADDR_REFRAC: period_d = bus.cfg_wdata[REFRAC_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Per-neuron integrate, saturate, fire and reset; neurons are fully independent.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cur[i]     = bus.current[i*W +: W];
            leak[i]    = state_q[i] >> BETA_SHIFT;
            sum_w[i]   = {1'b0, cur[i]} + {1'b0, leak[i]};
            sum[i]     = sum_w[i][W] ? {W{1'b1}} : sum_w[i][W-1:0];
            state_d[i] = state_q[i];
            spike_d[i] = 1'b0;
`ifdef LIF_REFRACTORY_EN
            cnt_d[i]   = cnt_q[i];
`endif
            if (bus.step) begin
`ifdef LIF_REFRACTORY_EN
                if (cnt_q[i] != '0) begin
                    cnt_d[i]   = cnt_q[i] - REFRAC_W'(1);
                    state_d[i] = leak[i];
                end else
`endif
                if (sum[i] >= thresh_q) begin
                    spike_d[i] = 1'b1;
                    state_d[i] = mode_q ? (sum[i] - thresh_q) : '0;
`ifdef LIF_REFRACTORY_EN
                    cnt_d[i]   = period_q;
`endif
                end else begin
                    state_d[i] = sum[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thresh_q <= THRESH_RST;
            mode_q   <= 1'b0;
            spike_q  <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= '0;
            end
`ifdef LIF_REFRACTORY_EN
            period_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
`endif
        end else begin
            thresh_q <= thresh_d;
            mode_q   <= mode_d;
            spike_q  <= spike_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
`ifdef LIF_REFRACTORY_EN
            period_q <= period_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`endif
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.state[g*W +: W] = state_q[g];
    end
    assign bus.spike = spike_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed self-checking bench for lif_array (N=4, W=8, BETA_SHIFT=1).
module tb_lif_array;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    lif_array_if #(.N(N), .W(W)) bus ();

    lif_array #(.N(N), .W(W), .BETA_SHIFT(1), .REFRAC_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic set_cur(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        bus.current = {c3, c2, c1, c0};
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.step = 1'b0;
        tick();
        rst_n    = 1'b1;
    endtask

    function automatic logic [31:0] st(input int i);
        return 32'(bus.state[i*W +: W]);
    endfunction

    initial begin
        int seq [7];
        logic [3:0] exp_spk;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.step      = 1'b0;
        bus.current   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        check_val("reset_state", 32'(bus.state), 32'd0);
        check_val("reset_spike", 32'(bus.spike), 32'd0);

        // Integration towards default threshold 127
        seq = '{64, 96, 112, 120, 124, 126, 0};
        set_cur(8'd64, 8'd0, 8'd0, 8'd0);
        bus.step = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_val($sformatf("integ_state0_step%0d", k + 1), st(0), 32'(seq[k]));
            check_val($sformatf("integ_spike_step%0d", k + 1), 32'(bus.spike),
                      (k == 6) ? 32'd1 : 32'd0);
        end
        check_val("integ_others_zero", 32'(bus.state[N*W-1:W]), 32'd0);

        // Gaps hold state with no spikes
        tick();
        check_val("gap_pre_state0", st(0), 32'd64);
        bus.step = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("gap_hold_state0_%0d", k), st(0), 32'd64);
            check_val($sformatf("gap_spike_%0d", k), 32'(bus.spike), 32'd0);
        end

        // Saturation and mode 1 (residual subtract)
        do_reset();
        cfg_write(2'd0, 8'd255);
        set_cur(8'd200, 8'd10, 8'd0, 8'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check_val("sat_pre_state0", st(0), 32'd200);
        check_val("sat_pre_state1", st(1), 32'd10);
        cfg_write(2'd0, 8'd127);
        cfg_write(2'd2, 8'd1);
        set_cur(8'd255, 8'd10, 8'd0, 8'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check_val("sat_spike", 32'(bus.spike), 32'd1);
        check_val("sat_mode1_state0", st(0), 32'd128);
        check_val("sat_state1", st(1), 32'd15);

        // Threshold 0: every neuron fires even with zero input
        cfg_write(2'd2, 8'd0);
        cfg_write(2'd0, 8'd0);
        set_cur(8'd0, 8'd0, 8'd0, 8'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check_val("thr0_spike", 32'(bus.spike), 32'hF);
        check_val("thr0_state", 32'(bus.state), 32'd0);

        // Config write colliding with step uses the old threshold
        do_reset();
        set_cur(8'd100, 8'd0, 8'd0, 8'd0);
        bus.step      = 1'b1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 8'd50;
        tick();
        bus.cfg_we    = 1'b0;
        check_val("coll_spike", 32'(bus.spike), 32'd0);
        check_val("coll_state0", st(0), 32'd100);
        tick();
        bus.step = 1'b0;
        check_val("coll_next_spike", 32'(bus.spike), 32'd1);
        check_val("coll_next_state0", st(0), 32'd0);

        // Reserved address is ignored (threshold stays 50)
        cfg_write(2'd3, 8'd0);
        set_cur(8'd40, 8'd0, 8'd0, 8'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check_val("addr3_spike", 32'(bus.spike), 32'd0);
        check_val("addr3_state0", st(0), 32'd40);

        // Refractory period 3
        do_reset();
        cfg_write(2'd1, 8'd3);
        set_cur(8'd200, 8'd0, 8'd0, 8'd0);
        bus.step = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
`ifdef LIF_REFRACTORY_EN
            exp_spk = (k == 1 || k == 5) ? 4'd1 : 4'd0;
`else
            exp_spk = 4'd1;
`endif
            check_val($sformatf("refr_spike_step%0d", k), 32'(bus.spike), 32'(exp_spk));
            check_val($sformatf("refr_state0_step%0d", k), st(0), 32'd0);
        end

        // Mid-refractory reset clears everything; next step integrates at once
        bus.step = 1'b0;
        do_reset();
        check_val("midrst_state", 32'(bus.state), 32'd0);
        check_val("midrst_spike", 32'(bus.spike), 32'd0);
        set_cur(8'd64, 8'd0, 8'd0, 8'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check_val("midrst_integ_state0", st(0), 32'd64);
        check_val("midrst_integ_spike", 32'(bus.spike), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  N           4  number of neurons
  W           8  membrane/current width in bits
  BETA_SHIFT  1  leak right-shift amount, beta = 2^-BETA_SHIFT, range 0..W-1
  REFRAC_W    4  refractory counter width in bits
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk        in   1       clock, all state updates on rising edge
  rst_n      in   1       reset, synchronous, active-low
  step       in   1       time-step strobe; neurons update only when high
  current    in   N*W     input currents, neuron i at bits [i*W +: W], unsigned
  cfg_we     in   1       configuration write enable
  cfg_addr   in   2       0 threshold, 1 refractory period, 2 mode, 3 reserved
  cfg_wdata  in   W       configuration write data
  spike      out  N       registered spike flags, bit i for neuron i
  state      out  N*W     registered membrane potentials, same packing as current

Function
REQ-003 On a clk edge with step=1, every neuron SHALL compute sum_i = current_i + (state_i >> BETA_SHIFT), in W+1 bits, then clamp to 2^W-1.
REQ-004 If sum_i >= threshold, the neuron SHALL set spike_i=1. state_i SHALL become 0 when mode[0]=0, or sum_i - threshold when mode[0]=1.
REQ-005 If sum_i < threshold, the neuron SHALL set state_i=sum_i and spike_i=0.
REQ-006 With step=0, state SHALL hold and every spike bit SHALL be 0 after the edge. Each spike is a one-cycle pulse per spiking step.
REQ-007 Latency SHALL be one cycle: inputs sampled at edge k appear on state/spike after edge k.
REQ-008 All N neurons SHALL update in the same cycle. There SHALL be no interaction between neurons.
REQ-009 A cfg write SHALL take effect on the edge that samples cfg_we=1. A step in that same cycle SHALL use the pre-write value.
REQ-010 Writes to cfg_addr 3 SHALL be ignored. Mode uses cfg_wdata[0] only. Refractory period uses cfg_wdata[REFRAC_W-1:0].
REQ-011 threshold=0 SHALL be legal: every non-refractory neuron spikes on every step.
REQ-012 The comparison and subtraction SHALL be unsigned. The mode-1 result SHALL never underflow, because sum_i >= threshold.

Reset
REQ-013 With rst_n=0 at a clk edge, the block SHALL set: all state to 0, all spike to 0, threshold to 2^(W-1)-1 (127 for W=8), refractory period to 0, mode to 0, all refractory counters to 0.
REQ-014 Reset SHALL take priority over step and cfg_we in the same cycle, and SHALL abort any refractory interval in progress.

Configuration
REQ-015 Macro LIF_REFRACTORY_EN defined: each neuron SHALL have a REFRAC_W-bit counter.
  - A spike loads the counter with the refractory period.
  - While the counter is nonzero, a step SHALL decrement it, set state_i = state_i >> BETA_SHIFT (current ignored) and force spike_i=0.
  - Period 0 SHALL give no refractory gap.
REQ-016 Macro LIF_REFRACTORY_EN not defined: the block SHALL contain no counters, and writes to cfg_addr 1 SHALL be ignored. Behaviour SHALL match refractory period 0.

Verification
REQ-017 The bench SHALL cover these scenarios (N=4, W=8, BETA_SHIFT=1, defaults unless stated):
  - Reset: after rst_n=0 for 1 cycle -> state=0, spike=0; a threshold of 127 is confirmed by scenario 2.
  - Integration: current0=64, step every cycle -> state0 = 64, 96, 112, 120, 124, 126; 7th step sum 127 -> spike[0]=1, state0=0. Neurons 1-3 with current 0 stay at 0.
  - Saturation and mode 1: mode=1, state0=200, current0=255 -> sum clamps to 255, spike[0]=1, state0=128.
  - Refractory (LIF_REFRACTORY_EN): period=3, current0=200 -> spike at step 1; steps 2-4 spike=0, state0=0; step 5 spike[0]=1. Without the macro -> spike on every step.
  - Config/step collision: cfg_we with threshold=50 in the same cycle as step with sum 100 -> compared against 127, no spike. The next step with sum 150 -> spike under 50.
  - Gaps and mid-run reset: step=0 for 5 cycles holds state, spike=0. rst_n=0 during a refractory interval -> all state and counters zero; the next step integrates immediately.
